// File: rtl/uart_frame_tx_arbiter_pkg.sv
// Shared definitions for the UART frame transmit arbiter.
// Holds the one-hot FSM encoding, the framing delimiter and the payload
// length limit derivation used by the arbiter top level.
package uart_frame_tx_arbiter_pkg;

  // One-hot so each state decodes from a single flop.
  typedef enum logic [3:0] {
    ST_IDLE      = 4'b0001,
    ST_ISSUE     = 4'b0010,
    ST_WAIT_DONE = 4'b0100,
    ST_GAP       = 4'b1000
  } arb_state_t;

  // Delimiter the downstream framer wraps around each payload ("&&payload&&").
  localparam logic [7:0] FRAME_DELIM = 8'h26;

  // Longest payload that fits the payload vector, clamped to the 8-bit length field.
  function automatic int max_len_of(input int str_w);
    return ((str_w / 8) > 255) ? 255 : (str_w / 8);
  endfunction

endpackage

// File: rtl/uart_frame_tx_arbiter_rr_pick_nxt.sv
// Round-robin selector: first asserted request strictly after rr_ptr, wrapping.
// Latency: purely combinational. Backpressure: none, evaluated every cycle.
// Ports: req_vld (request vector), rr_ptr (last winner) -> found, idx (winner).
module uart_frame_tx_arbiter_rr_pick_nxt #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_vld,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  int cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    // Walk rr_ptr+1 .. rr_ptr+NUM_REQ so the last winner has lowest priority.
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && req_vld[IDX_W'(cand)]) begin
        found = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_frame_tx_arbiter.sv
// Round-robin arbiter sharing one UART string framer among NUM_REQ requesters.
// Latency: grant -> frm_req 1 cycle; frm_done -> req_done 1 cycle; GAP_CLK idle cycles after each frame.
// Backpressure: requests are level-held until req_ack; requests seen while busy wait for IDLE.
// Ports: sys_clk/sys_rst_n; req_vld/req_string/req_length in, req_ack/req_done/req_err out;
//        frm_string/frm_length/frm_req to the framer, frm_done back; busy, cur_grant status.
module uart_frame_tx_arbiter
  import uart_frame_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int STR_W       = 1096,
  parameter int MAX_LEN     = max_len_of(STR_W),
  parameter int TIMEOUT_CLK = 50_000_000,
  parameter int GAP_CLK     = 1000
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic [NUM_REQ-1:0]         req_vld,
  input  logic [NUM_REQ*STR_W-1:0]   req_string,
  input  logic [NUM_REQ*8-1:0]       req_length,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [NUM_REQ-1:0]         req_done,
  output logic                       req_err,
  output logic [STR_W-1:0]           frm_string,
  output logic [7:0]                 frm_length,
  output logic                       frm_req,
  input  logic                       frm_done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] cur_grant
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMO_W = (TIMEOUT_CLK < 1) ? 1 : $clog2(TIMEOUT_CLK + 1);
  localparam int GAP_W = (GAP_CLK < 1) ? 1 : $clog2(GAP_CLK + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'((TIMEOUT_CLK > 0) ? TIMEOUT_CLK - 1 : 0);
  // GAP_CLK of 0 still spends one cycle in GAP.
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CLK > 0) ? GAP_CLK - 1 : 0);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

  arb_state_t         state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr, pick_idx;
  logic               pick_found;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [7:0]         len_arr [NUM_REQ];
  logic [STR_W-1:0]   str_arr [NUM_REQ];
  logic [7:0]         pick_len;
  logic               len_bad;
  logic               grant, tmo_inc, gap_inc;
  logic [NUM_REQ-1:0] ack_nxt, done_nxt;
  logic               err_nxt, frq_nxt;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign str_arr[g] = req_string[g*STR_W +: STR_W];
    assign len_arr[g] = req_length[g*8 +: 8];
  end

  uart_frame_tx_arbiter_rr_pick_nxt #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_vld (req_vld),
    .rr_ptr  (rr_ptr),
    .found   (pick_found),
    .idx     (pick_idx)
  );

  assign pick_len = len_arr[pick_idx];
  assign len_bad  = (pick_len == 8'd0) || (pick_len > MAX_LEN_B);
  assign busy     = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    ack_nxt   = '0;
    done_nxt  = '0;
    err_nxt   = 1'b0;
    frq_nxt   = 1'b0;
    tmo_inc   = 1'b0;
    gap_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          grant            = 1'b1;
          ack_nxt[pick_idx] = 1'b1;
          if (len_bad) begin
            // Rejected payloads never reach the framer but still pay the gap.
            done_nxt[pick_idx] = 1'b1;
            err_nxt            = 1'b1;
            state_nxt          = ST_GAP;
          end else begin
            state_nxt = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        frq_nxt   = 1'b1;
        state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // frm_done is checked first so a completion on the timeout cycle is not an error.
        if (frm_done) begin
          done_nxt[cur_grant] = 1'b1;
          state_nxt           = ST_GAP;
        end else if (tmo_cnt == TMO_LAST) begin
          done_nxt[cur_grant] = 1'b1;
          err_nxt             = 1'b1;
          state_nxt           = ST_GAP;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
        else                     gap_inc   = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      rr_ptr     <= IDX_W'(NUM_REQ - 1);
      cur_grant  <= '0;
      frm_string <= '0;
      frm_length <= '0;
      req_ack    <= '0;
      req_done   <= '0;
      req_err    <= 1'b0;
      frm_req    <= 1'b0;
      tmo_cnt    <= '0;
      gap_cnt    <= '0;
    end else begin
      state    <= state_nxt;
      req_ack  <= ack_nxt;
      req_done <= done_nxt;
      req_err  <= err_nxt;
      frm_req  <= frq_nxt;
      if (grant) begin
        rr_ptr     <= pick_idx;
        cur_grant  <= pick_idx;
        frm_string <= str_arr[pick_idx];
        frm_length <= pick_len;
      end
      // Counters only run in their own state and are held at zero elsewhere.
      if (state != ST_WAIT_DONE) tmo_cnt <= '0;
      else if (tmo_inc)          tmo_cnt <= tmo_cnt + 1'b1;
      if (state != ST_GAP)       gap_cnt <= '0;
      else if (gap_inc)          gap_cnt <= gap_cnt + 1'b1;
    end
  end

endmodule
